// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared divider controller types and result layout constants
package div_ctrl_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_RUN     = S_RUN,
    ST_DRAIN   = S_DRAIN,
    ST_RELEASE = S_RELEASE
  } div_state_t;

  localparam int REQ_ID_W = 1;
  localparam int REM_MSB  = 63;
  localparam int REM_LSB  = 32;
  localparam int QUO_MSB  = 31;
  localparam int RES_W    = REM_MSB + 1;
  localparam int OP_W     = QUO_MSB + 1;

endpackage

// File: rtl/div_rr_arb2.sv
// rtl/div_rr_arb2.sv - two-way round-robin grant with pointer update on advance
module div_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    grant    = valid;
    next_ptr = ptr;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
    // the pointer moves to whichever requester did not win
    if (advance && (|grant)) begin
      next_ptr = ~grant[1];
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - arbitrates and sequences one shared iterative divider between two requesters
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 63,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_signed,
  input  logic [OP_W-1:0]  req0_op1,
  input  logic [OP_W-1:0]  req0_op2,
  input  logic             req0_cancel,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [RES_W-1:0] rsp0_result,
  output logic             rsp0_dbz,
  output logic             rsp0_err,
  input  logic             req1_valid,
  input  logic             req1_signed,
  input  logic [OP_W-1:0]  req1_op1,
  input  logic [OP_W-1:0]  req1_op2,
  input  logic             req1_cancel,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [RES_W-1:0] rsp1_result,
  output logic             rsp1_dbz,
  output logic             rsp1_err,
  output logic             div_start_o,
  output logic             div_signed_o,
  output logic [OP_W-1:0]  div_op1_o,
  output logic [OP_W-1:0]  div_op2_o,
  input  logic             div_ready_i,
  input  logic [RES_W-1:0] div_result_i,
  output logic             busy_o
);

  div_state_t          state, state_nxt;
  logic                rr_ptr, rr_next;
  logic [1:0]          arb_valid, grant;
  logic                accept, rsp_fire, rsp_err_nxt, cancel_own, wdog_hit;
  logic [REQ_ID_W-1:0] owner_q;
  logic                signed_q, dbz_q;
  logic [OP_W-1:0]     op1_q, op2_q;
  logic [CNT_W-1:0]    wdog;

  assign arb_valid = (state == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;

  div_rr_arb2 u_arb (
    .valid    (arb_valid),
    .ptr      (rr_ptr),
    .advance  (accept),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign div_start_o  = (state == ST_RUN) || (state == ST_DRAIN);
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign busy_o       = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    accept      = |grant;
    rsp_fire    = 1'b0;
    rsp_err_nxt = 1'b0;
    cancel_own  = owner_q[0] ? req1_cancel : req0_cancel;
    wdog_hit    = (wdog == CNT_W'(WDOG_CYCLES));
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // a cancelled op never responds, even if the divider finishes in the same cycle
        if (cancel_own) begin
          state_nxt = div_ready_i ? ST_RELEASE : ST_DRAIN;
        end else if (div_ready_i) begin
          rsp_fire  = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (wdog_hit) begin
          rsp_fire    = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = ST_RELEASE;
        end
      end
      ST_DRAIN: begin
        if (div_ready_i || wdog_hit) state_nxt = ST_RELEASE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      owner_q     <= '0;
      signed_q    <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      dbz_q       <= 1'b0;
      wdog        <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_dbz    <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_dbz    <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rsp0_valid <= rsp_fire && !owner_q[0];
      rsp1_valid <= rsp_fire && owner_q[0];
      if (accept) begin
        rr_ptr   <= rr_next;
        owner_q  <= REQ_ID_W'(grant[1]);
        signed_q <= grant[1] ? req1_signed : req0_signed;
        op1_q    <= grant[1] ? req1_op1 : req0_op1;
        op2_q    <= grant[1] ? req1_op2 : req0_op2;
        dbz_q    <= grant[1] ? (req1_op2 == '0) : (req0_op2 == '0);
        wdog     <= '0;
      end else if (div_start_o) begin
        wdog <= wdog + CNT_W'(1);
      end
      if (rsp_fire && !owner_q[0]) begin
        rsp0_result <= rsp_err_nxt ? '0 : div_result_i;
        rsp0_dbz    <= dbz_q;
        rsp0_err    <= rsp_err_nxt;
      end
      if (rsp_fire && owner_q[0]) begin
        rsp1_result <= rsp_err_nxt ? '0 : div_result_i;
        rsp1_dbz    <= dbz_q;
        rsp1_err    <= rsp_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - directed self-checking bench for div_share_ctrl
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req0_signed = 1'b0, req0_cancel = 1'b0;
  logic [31:0] req0_op1 = '0, req0_op2 = '0;
  logic        req1_valid = 1'b0, req1_signed = 1'b0, req1_cancel = 1'b0;
  logic [31:0] req1_op1 = '0, req1_op2 = '0;
  logic        req0_ready, rsp0_valid, rsp0_dbz, rsp0_err;
  logic        req1_ready, rsp1_valid, rsp1_dbz, rsp1_err;
  logic [63:0] rsp0_result, rsp1_result;
  logic        div_start_o, div_signed_o, busy_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        div_ready_i = 1'b0;
  logic [63:0] div_result_i = '0;

  int npass = 0, nfail = 0, nchk = 0;
  int lat = 4;
  int mcnt = 0;
  logic mdone = 1'b0;
  logic mon_arm = 1'b0, op_moved = 1'b0, exp_sgn = 1'b0;
  logic [31:0] exp_op1 = '0, exp_op2 = '0;

  always #5 clk = ~clk;

  div_share_ctrl #(.WDOG_CYCLES(63), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_cancel(req0_cancel), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_result(rsp0_result), .rsp0_dbz(rsp0_dbz), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_cancel(req1_cancel), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_result(rsp1_result), .rsp1_dbz(rsp1_dbz), .rsp1_err(rsp1_err),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o), .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .busy_o(busy_o)
  );

  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // divider model: ready pulses once, lat cycles after start rises
  always @(posedge clk) begin
    if (!div_start_o) begin
      mcnt <= 0;
      mdone <= 1'b0;
      div_ready_i <= 1'b0;
    end else if (!mdone) begin
      if (mcnt == lat - 1) begin
        div_ready_i <= 1'b1;
        div_result_i <= div_model(div_signed_o, div_op1_o, div_op2_o);
        mdone <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      div_ready_i <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_arm && busy_o &&
        (div_op1_o !== exp_op1 || div_op2_o !== exp_op2 || div_signed_o !== exp_sgn))
      op_moved <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n, output int cyc, output logic prev_rdy);
    logic r;
    cyc = 0;
    prev_rdy = 1'b0;
    while (cyc < 200) begin
      r = div_ready_i;
      tick();
      cyc++;
      if ((n == 0) ? rsp0_valid : rsp1_valid) begin
        prev_rdy = r;
        return;
      end
    end
  endtask

  initial begin
    int cyc, n;
    logic prdy, r, bad;

    repeat (3) tick();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_start", 64'(div_start_o), 64'd0);
    check("rst_rsp0", {rsp0_result[62:0], rsp0_valid}, 64'd0);
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    rst = 1'b1;
    tick();

    // unsigned 100/7 alone
    lat = 4;
    req0_valid = 1'b1; req0_signed = 1'b0; req0_op1 = 32'd100; req0_op2 = 32'd7;
    #1;
    check("t1_ready0", 64'(req0_ready), 64'd1);
    check("t1_ready1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    check("t1_start", 64'(div_start_o), 64'd1);
    check("t1_ops", {div_op1_o, div_op2_o}, {32'd100, 32'd7});
    wait_rsp(0, cyc, prdy);
    check("t1_latency", 64'(cyc), 64'd5);
    check("t1_prev_ready", 64'(prdy), 64'd1);
    check("t1_result", rsp0_result, {32'd2, 32'd14});
    check("t1_dbz_err", 64'({rsp0_dbz, rsp0_err}), 64'd0);
    check("t1_release", 64'({busy_o, div_start_o}), 64'b10);
    tick();
    check("t1_pulse", 64'(rsp0_valid), 64'd0);
    check("t1_hold", rsp0_result, {32'd2, 32'd14});
    check("t1_idle", 64'(busy_o), 64'd0);

    // signed -7/2 with operand stability and a non-owner cancel
    lat = 6;
    req0_valid = 1'b1; req0_signed = 1'b1; req0_op1 = 32'hFFFF_FFF9; req0_op2 = 32'd2;
    exp_op1 = 32'hFFFF_FFF9; exp_op2 = 32'd2; exp_sgn = 1'b1;
    tick();
    req0_valid = 1'b0; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_signed = 1'b0;
    mon_arm = 1'b1;
    tick(); tick();
    req1_cancel = 1'b1;
    tick();
    req1_cancel = 1'b0;
    wait_rsp(0, cyc, prdy);
    check("t2_arrived", 64'(rsp0_valid), 64'd1);
    check("t2_result", rsp0_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    mon_arm = 1'b0;
    check("t2_op_stable", 64'(op_moved), 64'd0);

    // contention after reset
    rst = 1'b0; tick(); rst = 1'b1; tick();
    lat = 4;
    req0_valid = 1'b1; req0_op1 = 32'd20; req0_op2 = 32'd3;
    req1_valid = 1'b1; req1_signed = 1'b0; req1_op1 = 32'd50; req1_op2 = 32'd5;
    #1;
    check("t3_grant_first", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 1'b0;
    check("t3_run_no_ready1", 64'(req1_ready), 64'd0);
    wait_rsp(0, cyc, prdy);
    check("t3_result0", rsp0_result, {32'd2, 32'd6});
    check("t3_release_no_ready1", 64'(req1_ready), 64'd0);
    tick();
    check("t3_idle_ready1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp(1, cyc, prdy);
    check("t3_result1", rsp1_result, {32'd0, 32'd10});
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t3_grant_third", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0, cyc, prdy);
    tick();

    // divide by zero on requester 1
    req1_valid = 1'b1; req1_op1 = 32'd9; req1_op2 = 32'd0;
    tick();
    req1_valid = 1'b0;
    wait_rsp(1, cyc, prdy);
    check("t4_arrived", 64'(rsp1_valid), 64'd1);
    check("t4_dbz_err", 64'({rsp1_dbz, rsp1_err}), 64'b10);
    check("t4_result", rsp1_result, 64'd0);
    tick();

    // owner cancel with requester 1 pending
    lat = 12;
    req0_valid = 1'b1; req0_op1 = 32'd30; req0_op2 = 32'd4;
    req1_valid = 1'b1; req1_op1 = 32'd77; req1_op2 = 32'd7;
    #1;
    check("t5_grant0", 64'({req1_ready, req0_ready}), 64'b01);
    tick();
    req0_valid = 1'b0;
    repeat (5) tick();
    req0_cancel = 1'b1;
    tick();
    req0_cancel = 1'b0;
    check("t5_drain_start", 64'({busy_o, div_start_o}), 64'b11);
    bad = 1'b0; n = 0;
    do begin
      r = div_ready_i;
      if (!div_start_o) bad = 1'b1;
      tick();
      n++;
      if (rsp0_valid) bad = 1'b1;
    end while (!r && n < 50);
    check("t5_drain_clean", 64'(bad), 64'd0);
    check("t5_drain_len", 64'(n), 64'd7);
    check("t5_release", 64'({busy_o, div_start_o, req1_ready}), 64'b100);
    tick();
    check("t5_idle_ready1", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp(1, cyc, prdy);
    check("t5_result1", rsp1_result, {32'd0, 32'd11});
    check("t5_no_rsp0", 64'(rsp0_valid), 64'd0);
    tick();

    // watchdog abort
    lat = 70;
    req0_valid = 1'b1; req0_op1 = 32'd1000; req0_op2 = 32'd3;
    tick();
    req0_valid = 1'b0;
    wait_rsp(0, cyc, prdy);
    check("t6_wdog_cycles", 64'(cyc), 64'd64);
    check("t6_err_dbz", 64'({rsp0_err, rsp0_dbz}), 64'b10);
    check("t6_result", rsp0_result, 64'd0);
    tick();

    // asynchronous reset mid-run
    lat = 10;
    req0_valid = 1'b1; req0_op1 = 32'd8; req0_op2 = 32'd2;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    check("t7_running", 64'(div_start_o), 64'd1);
    rst = 1'b0;
    #1;
    check("t7_async_ctl", 64'({busy_o, div_start_o, rsp0_err}), 64'd0);
    check("t7_async_op", 64'(div_op1_o), 64'd0);
    check("t7_async_rsp1", rsp1_result, 64'd0);
    rst = 1'b1;
    tick();
    check("t7_idle", 64'({busy_o, req0_ready}), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Arbitrates and sequences one shared iterative divider (radix-4, 64-bit {remainder,quotient} result) between two requesters.
- Requester 0 is the EX-stage DIV/DIVU path; requester 1 is the secondary (coprocessor/debug) path.
- Captures and holds operands stable for the divider's whole run, drives the divider's start level, and returns the result to the owning requester.
- Handles cancels (pipeline flush) by draining the divider safely.

Parameters:
- WDOG_CYCLES, 63: max cycles in RUN before forced abort with an error response.
- CNT_W, 6: watchdog counter width; must satisfy 2^CNT_W > WDOG_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_signed  in  1  signed divide
- req0_op1  in  32  dividend
- req0_op2  in  32  divisor
- req0_cancel  in  1  abort requester 0's in-flight op
- req0_ready  out  1  op accepted this cycle
- rsp0_valid  out  1  one-cycle result pulse
- rsp0_result  out  64  {remainder[63:32], quotient[31:0]}
- rsp0_dbz  out  1  divisor was zero
- rsp0_err  out  1  watchdog abort
- req1_*/rsp1_*  same as requester 0
- div_start_o  out  1  divider start level
- div_signed_o  out  1  to divider
- div_op1_o  out  32  to divider
- div_op2_o  out  32  to divider
- div_ready_i  in  1  divider ready
- div_result_i  in  64  divider result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr pointer=0; all outputs 0; operand, owner and response registers 0.
- States: IDLE, RUN, DRAIN, RELEASE (encodings in the package).
- IDLE:
  - reqN_ready = reqN_valid & grantN (combinational).
  - Grant on single request: that requester. Both valid: the requester selected by the rr pointer.
  - On accept: latch signed/op1/op2, owner id, dbz=(op2==0); clear watchdog; flip rr pointer to the other requester; set div_start_o=1 at the next edge; go to RUN.
- RUN:
  - div_start_o=1; div_op*/div_signed_o come from latches and are constant until RELEASE ends. The divider samples operand signs again at completion, so this stability is mandatory.
  - div_ready_i=1 and no owner cancel: capture div_result_i; at the next edge pulse rspOWNER_valid for exactly 1 cycle with result and dbz; div_start_o=0; go to RELEASE.
  - Owner cancel: go to DRAIN; no response is ever issued for that op.
  - Cancel and div_ready_i in the same cycle: cancel wins; go straight to RELEASE with no response.
  - Cancel from the non-owner: ignored.
  - Watchdog reaches WDOG_CYCLES: response with rsp_err=1, result=0; go to RELEASE.
- DRAIN:
  - Keep div_start_o=1 until div_ready_i=1, because the divider cannot abort mid-iteration.
  - Then go to RELEASE; result discarded.
  - The watchdog also applies here (exit to RELEASE silently).
- RELEASE:
  - div_start_o=0 for exactly one cycle so the divider returns to its free state; then go to IDLE.
  - No accept in RELEASE; next accept is possible the cycle after.
- Latency: rsp_valid asserts 1 cycle after div_ready_i is first sampled 1.
- Back-to-back ops: minimum accept-to-accept spacing = divider latency + 3 cycles.
- Divide-by-zero: passed to the divider unchanged; it returns 0; rsp_dbz=1.
- rspN_result/dbz/err hold their value after the pulse until the next response to that requester.

Decomposition:
- Package div_ctrl_pkg:
  - State encoding localparams (2 bits).
  - REQ_ID width (1).
  - Result layout constants: REM_MSB=63, REM_LSB=32, QUO_MSB=31.
- Sub-module div_rr_arb2: 2-way round-robin grant; inputs are the valid bits, pointer, and advance; outputs are the grants and the next pointer.

Test Plan:
- Req0 unsigned 100/7 alone -> req0_ready in cycle 0; rsp0_valid one cycle after div_ready_i; result {32'd2, 32'd14}; dbz=0, err=0.
- Req0 signed -7/2 -> result {32'hFFFF_FFFF, 32'hFFFF_FFFD} (rem -1, quo -3); div_op1_o/div_op2_o stable for the entire RUN.
- Req0 and req1 valid in the same cycle after reset -> req0 granted first; req1 (50/5 -> {0, 10}) granted the cycle after RELEASE; the third contention grants req0 again.
- Req1 op2=0 -> rsp1_dbz=1, rsp1_result=0, no hang.
- Req0 cancel 5 cycles into RUN -> controller holds start until div_ready_i, 1 RELEASE cycle, no rsp0_valid; a pending req1 is accepted next.
- Divider model withholds ready for 70 cycles -> rsp_err=1 at cycle 63 of RUN. Separately, assert rst mid-RUN -> all outputs 0 immediately and IDLE after release.
